// File: rtl/aclock_set_ctrl.sv
// Push-button time/alarm setting controller for the aclock configuration inputs.
// Button presses are registered (1-cycle latency), then drive an IDLE/HR/MIN/LOAD
// editor that produces BCD values and a time or alarm load strobe.
module aclock_set_ctrl #(
  parameter int unsigned REPEAT_DLY  = 50,
  parameter int unsigned REPEAT_RATE = 10,
  parameter int unsigned TIMEOUT     = 1000,
  parameter int unsigned LD_CYCLES   = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_time,
  input  logic       btn_alarm,
  input  logic       btn_inc,
  input  logic       btn_ok,
  input  logic [1:0] H_out1,
  input  logic [3:0] H_out0,
  input  logic [3:0] M_out1,
  input  logic [3:0] M_out0,
  output logic [1:0] H_in1,
  output logic [3:0] H_in0,
  output logic [3:0] M_in1,
  output logic [3:0] M_in0,
  output logic       LD_time,
  output logic       LD_alarm,
  output logic       editing,
  output logic [1:0] field
);

  localparam int unsigned HOLD_W = $clog2(REPEAT_DLY + 1);
  localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);
  localparam int unsigned LD_W   = $clog2(LD_CYCLES + 1);
  localparam int unsigned B_TIME  = 0;
  localparam int unsigned B_ALARM = 1;
  localparam int unsigned B_INC   = 2;
  localparam int unsigned B_OK    = 3;

  typedef enum logic [1:0] {S_IDLE, S_HR, S_MIN, S_LOAD} state_e;

  state_e              state_q, state_d;
  logic                tgt_alarm_q, tgt_alarm_d;
  logic [1:0]          h1_q, h1_d, al_h1_q, al_h1_d;
  logic [3:0]          h0_q, h0_d, al_h0_q, al_h0_d;
  logic [3:0]          m1_q, m1_d, al_m1_q, al_m1_d;
  logic [3:0]          m0_q, m0_d, al_m0_q, al_m0_d;
  logic [3:0]          hist_q, hist_d, press_q, press_d;
  logic                hold_act_q, hold_act_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [IDLE_W-1:0]   idle_cnt_q, idle_cnt_d;
  logic [LD_W-1:0]     ld_cnt_q, ld_cnt_d;
  logic                editing_q, editing_d;
  logic [1:0]          field_q, field_d;
  logic                ld_time_q, ld_time_d;
  logic                ld_alarm_q, ld_alarm_d;

  logic [3:0]          btn;
  logic [1:0]          pre_h1;
  logic [3:0]          pre_h0, pre_m1, pre_m0;
  logic                do_inc;

  assign btn = {btn_ok, btn_inc, btn_alarm, btn_time};

  assign H_in1    = h1_q;
  assign H_in0    = h0_q;
  assign M_in1    = m1_q;
  assign M_in0    = m0_q;
  assign LD_time  = ld_time_q;
  assign LD_alarm = ld_alarm_q;
  assign editing  = editing_q;
  assign field    = field_q;

  // Clamp the live time read back from the aclock into a valid BCD preload
  always_comb begin
    pre_h1 = (H_out1 > 2'd2) ? 2'd2 : H_out1;
    if (pre_h1 == 2'd2) pre_h0 = (H_out0 > 4'd3) ? 4'd3 : H_out0;
    else                pre_h0 = (H_out0 > 4'd9) ? 4'd9 : H_out0;
    pre_m1 = (M_out1 > 4'd5) ? 4'd5 : M_out1;
    pre_m0 = (M_out0 > 4'd9) ? 4'd9 : M_out0;
  end

  // State and datapath registers; button history resets high to mask held buttons
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      tgt_alarm_q <= 1'b0;
      h1_q <= 2'd0; h0_q <= 4'd0; m1_q <= 4'd0; m0_q <= 4'd0;
      al_h1_q <= 2'd0; al_h0_q <= 4'd0; al_m1_q <= 4'd0; al_m0_q <= 4'd0;
      hist_q      <= 4'hF;
      press_q     <= 4'h0;
      hold_act_q  <= 1'b0;
      hold_cnt_q  <= '0;
      idle_cnt_q  <= '0;
      ld_cnt_q    <= '0;
      editing_q   <= 1'b0;
      field_q     <= 2'd0;
      ld_time_q   <= 1'b0;
      ld_alarm_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      tgt_alarm_q <= tgt_alarm_d;
      h1_q <= h1_d; h0_q <= h0_d; m1_q <= m1_d; m0_q <= m0_d;
      al_h1_q <= al_h1_d; al_h0_q <= al_h0_d; al_m1_q <= al_m1_d; al_m0_q <= al_m0_d;
      hist_q      <= hist_d;
      press_q     <= press_d;
      hold_act_q  <= hold_act_d;
      hold_cnt_q  <= hold_cnt_d;
      idle_cnt_q  <= idle_cnt_d;
      ld_cnt_q    <= ld_cnt_d;
      editing_q   <= editing_d;
      field_q     <= field_d;
      ld_time_q   <= ld_time_d;
      ld_alarm_q  <= ld_alarm_d;
    end
  end

  // Next state, edit values, auto-repeat and timeout counters
  always_comb begin
    state_d     = state_q;
    tgt_alarm_d = tgt_alarm_q;
    h1_d = h1_q; h0_d = h0_q; m1_d = m1_q; m0_d = m0_q;
    al_h1_d = al_h1_q; al_h0_d = al_h0_q; al_m1_d = al_m1_q; al_m0_d = al_m0_q;
    hist_d      = btn;
    press_d     = btn & ~hist_q;
    hold_act_d  = hold_act_q;
    hold_cnt_d  = hold_cnt_q;
    idle_cnt_d  = idle_cnt_q;
    ld_cnt_d    = ld_cnt_q;
    do_inc      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        hold_act_d = 1'b0;
        if (press_q[B_TIME]) begin
          h1_d = pre_h1; h0_d = pre_h0; m1_d = pre_m1; m0_d = pre_m0;
          tgt_alarm_d = 1'b0;
          idle_cnt_d  = '0;
          state_d     = S_HR;
        end else if (press_q[B_ALARM]) begin
          h1_d = al_h1_q; h0_d = al_h0_q; m1_d = al_m1_q; m0_d = al_m0_q;
          tgt_alarm_d = 1'b1;
          idle_cnt_d  = '0;
          state_d     = S_HR;
        end
      end
      S_HR, S_MIN: begin
        idle_cnt_d = (press_q != 4'h0) ? '0 : idle_cnt_q + IDLE_W'(1);
        if (press_q[B_TIME] || press_q[B_ALARM]) begin
          hold_act_d = 1'b0;
          state_d    = S_IDLE;
        end else if (press_q[B_OK]) begin
          hold_act_d = 1'b0;
          ld_cnt_d   = '0;
          if (state_q == S_HR) begin
            state_d = S_MIN;
          end else begin
            state_d = S_LOAD;
            if (tgt_alarm_q) begin
              al_h1_d = h1_q; al_h0_d = h0_q; al_m1_d = m1_q; al_m0_d = m0_q;
            end
          end
        end else if (press_q[B_INC]) begin
          do_inc     = 1'b1;
          hold_act_d = 1'b1;
          hold_cnt_d = '0;
        end else if (idle_cnt_q == IDLE_W'(TIMEOUT - 1)) begin
          hold_act_d = 1'b0;
          state_d    = S_IDLE;
        end else if (hold_act_q && btn_inc) begin
          if (hold_cnt_q == HOLD_W'(REPEAT_DLY - 1)) begin
            do_inc     = 1'b1;
            hold_cnt_d = HOLD_W'(REPEAT_DLY - REPEAT_RATE);
          end else begin
            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
          end
        end else begin
          hold_act_d = 1'b0;
        end

        if (do_inc && state_q == S_HR) begin
          if (h1_q == 2'd2 && h0_q == 4'd3) begin
            h1_d = 2'd0; h0_d = 4'd0;
          end else if (h0_q == 4'd9) begin
            h1_d = h1_q + 2'd1; h0_d = 4'd0;
          end else begin
            h0_d = h0_q + 4'd1;
          end
        end else if (do_inc) begin
          if (m0_q == 4'd9) begin
            m0_d = 4'd0;
            m1_d = (m1_q == 4'd5) ? 4'd0 : m1_q + 4'd1;
          end else begin
            m0_d = m0_q + 4'd1;
          end
        end
      end
      S_LOAD: begin
        hold_act_d = 1'b0;
        if (ld_cnt_q == LD_W'(LD_CYCLES - 1)) state_d = S_IDLE;
        else                                  ld_cnt_d = ld_cnt_q + LD_W'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Registered status and strobe outputs decoded from the next state
  always_comb begin
    editing_d  = (state_d != S_IDLE);
    field_d    = 2'd0;
    ld_time_d  = 1'b0;
    ld_alarm_d = 1'b0;
    if (state_d == S_HR)  field_d = 2'd1;
    if (state_d == S_MIN) field_d = 2'd2;
    if (state_d == S_LOAD) begin
      ld_time_d  = ~tgt_alarm_d;
      ld_alarm_d = tgt_alarm_d;
    end
  end

endmodule
